// File: rtl/fxp_pe_array_block.sv
// N x N sign-magnitude fixed-point matrix multiply on an outer-product PE array.
// Optional macro FXP_PE_ARRAY_ROUND_EN selects round-half-away-from-zero requantisation.
module fxp_pe_array_block #(
  parameter int N    = 4,
  parameter int DW   = 8,
  parameter int FRAC = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_in_data,
  output logic            rdy_in_data,
  input  logic            in_mat,
  input  logic            in_mat_done,
  input  logic [N*DW-1:0] in_data,
  output logic            en_out_data,
  input  logic            rdy_out_data,
  output logic            out_mat_done,
  output logic [N*DW-1:0] out_data
);

  localparam int PW    = (N > 1) ? $clog2(N) : 1;
  localparam int MW    = 2 * (DW - 1);
  localparam int ACC_W = MW + $clog2(N) + 1;
  localparam logic [PW-1:0] LAST = PW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  logic [N*DW-1:0] a_buf_q [N];
  logic [N*DW-1:0] a_buf_d [N];
  logic [N*DW-1:0] b_buf_q [N];
  logic [N*DW-1:0] b_buf_d [N];
  logic [N-1:0]    a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  logic [PW-1:0]   a_ptr_q, a_ptr_d, b_ptr_q, b_ptr_d;
  logic            pad_q, pad_d, pad_mat_q, pad_mat_d;

  state_t          state_q, state_d;
  logic [PW-1:0]   k_q, k_d;
  logic            issue, accept, load, out_xfer, out_free;

  logic            prod_vld_q, prod_vld_d, prod_last_q, prod_last_d;
  logic            acc_done_q, acc_done_d;
  logic            prod_sign_q [N][N];
  logic            prod_sign_d [N][N];
  logic [MW-1:0]   prod_mag_q [N][N];
  logic [MW-1:0]   prod_mag_d [N][N];
  logic signed [ACC_W-1:0] acc_q [N][N];
  logic signed [ACC_W-1:0] acc_d [N][N];

  logic [N*DW-1:0] out_reg_q [N];
  logic [N*DW-1:0] out_reg_d [N];
  logic            out_full_q, out_full_d;
  logic [PW-1:0]   row_q, row_d;

  function automatic logic [DW-1:0] requant(input logic signed [ACC_W-1:0] acc);
    logic [ACC_W-1:0] mag_abs;
    logic [ACC_W-1:0] mag_sh;
    mag_abs = acc[ACC_W-1] ? (~acc + 1'b1) : acc;
`ifdef FXP_PE_ARRAY_ROUND_EN
    mag_abs = mag_abs + ACC_W'(2 ** (FRAC - 1));
`endif
    mag_sh = mag_abs >> FRAC;
    if (mag_sh > ACC_W'(2 ** (DW - 1) - 1)) begin
      mag_sh = ACC_W'(2 ** (DW - 1) - 1);
    end
    return {acc[ACC_W-1] && (mag_sh != '0), mag_sh[DW-2:0]};
  endfunction

  assign rdy_in_data  = !rst && !pad_q && !(in_mat ? b_vld_q[b_ptr_q] : a_vld_q[a_ptr_q]);
  assign accept       = en_in_data && rdy_in_data;
  assign issue        = (state_q == IDLE || state_q == RUN) && a_vld_q[k_q] && b_vld_q[k_q];
  assign out_xfer     = out_full_q && rdy_out_data;
  assign out_free     = !out_full_q || (out_xfer && row_q == LAST);
  assign load         = (state_q == HOLD) && acc_done_q && out_free;
  assign en_out_data  = out_full_q;
  assign out_mat_done = out_full_q && (row_q == LAST);
  assign out_data     = out_full_q ? out_reg_q[row_q] : '0;

  // Operand buffers: accepted beats and zero-pad writes fill entries, step issue frees them.
  always_comb begin
    a_buf_d   = a_buf_q;
    b_buf_d   = b_buf_q;
    a_vld_d   = a_vld_q;
    b_vld_d   = b_vld_q;
    a_ptr_d   = a_ptr_q;
    b_ptr_d   = b_ptr_q;
    pad_d     = pad_q;
    pad_mat_d = pad_mat_q;
    if (issue) begin
      a_vld_d[k_q] = 1'b0;
      b_vld_d[k_q] = 1'b0;
    end
    if (accept) begin
      if (!in_mat) begin
        a_buf_d[a_ptr_q] = in_data;
        a_vld_d[a_ptr_q] = 1'b1;
        a_ptr_d = (a_ptr_q == LAST) ? '0 : a_ptr_q + 1'b1;
      end else begin
        b_buf_d[b_ptr_q] = in_data;
        b_vld_d[b_ptr_q] = 1'b1;
        b_ptr_d = (b_ptr_q == LAST) ? '0 : b_ptr_q + 1'b1;
      end
      if (in_mat_done && ((in_mat ? b_ptr_q : a_ptr_q) != LAST)) begin
        pad_d     = 1'b1;
        pad_mat_d = in_mat;
      end
    end else if (pad_q) begin
      if (!pad_mat_q && !a_vld_q[a_ptr_q]) begin
        a_buf_d[a_ptr_q] = '0;
        a_vld_d[a_ptr_q] = 1'b1;
        a_ptr_d = (a_ptr_q == LAST) ? '0 : a_ptr_q + 1'b1;
        pad_d   = (a_ptr_q != LAST);
      end else if (pad_mat_q && !b_vld_q[b_ptr_q]) begin
        b_buf_d[b_ptr_q] = '0;
        b_vld_d[b_ptr_q] = 1'b1;
        b_ptr_d = (b_ptr_q == LAST) ? '0 : b_ptr_q + 1'b1;
        pad_d   = (b_ptr_q != LAST);
      end
    end
  end

  // Step 0 issues straight out of IDLE so a full matrix needs exactly N issue cycles.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: if (issue) begin
        state_d = RUN;
        k_d     = PW'(1);
      end
      RUN: if (issue) begin
        if (k_q == LAST) begin
          state_d = HOLD;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      HOLD: if (load) state_d = IDLE;
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  always_comb begin
    logic signed [ACC_W-1:0] ext;
    ext         = '0;
    prod_vld_d  = issue;
    prod_last_d = issue && (state_q == RUN) && (k_q == LAST);
    prod_sign_d = prod_sign_q;
    prod_mag_d  = prod_mag_q;
    acc_d       = acc_q;
    acc_done_d  = acc_done_q;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (issue) begin
          prod_sign_d[i][j] = a_buf_q[k_q][i*DW+DW-1] ^ b_buf_q[k_q][j*DW+DW-1];
          prod_mag_d[i][j]  = {{(DW-1){1'b0}}, a_buf_q[k_q][i*DW +: DW-1]} *
                              {{(DW-1){1'b0}}, b_buf_q[k_q][j*DW +: DW-1]};
        end
        ext = signed'({{(ACC_W-MW){1'b0}}, prod_mag_q[i][j]});
        if (load) begin
          acc_d[i][j] = '0;
        end else if (prod_vld_q) begin
          acc_d[i][j] = prod_sign_q[i][j] ? acc_q[i][j] - ext : acc_q[i][j] + ext;
        end
      end
    end
    if (load) begin
      acc_done_d = 1'b0;
    end else if (prod_vld_q && prod_last_q) begin
      acc_done_d = 1'b1;
    end
  end

  // Output register: a load on the same edge as the last-row transfer keeps rows back to back.
  always_comb begin
    out_reg_d  = out_reg_q;
    out_full_d = out_full_q;
    row_d      = row_q;
    if (out_xfer) begin
      if (row_q == LAST) begin
        row_d      = '0;
        out_full_d = 1'b0;
      end else begin
        row_d = row_q + 1'b1;
      end
    end
    if (load) begin
      out_full_d = 1'b1;
      row_d      = '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          out_reg_d[i][j*DW +: DW] = requant(acc_q[i][j]);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_vld_q     <= '0;
      b_vld_q     <= '0;
      a_ptr_q     <= '0;
      b_ptr_q     <= '0;
      pad_q       <= 1'b0;
      pad_mat_q   <= 1'b0;
      state_q     <= IDLE;
      k_q         <= '0;
      prod_vld_q  <= 1'b0;
      prod_last_q <= 1'b0;
      acc_done_q  <= 1'b0;
      out_full_q  <= 1'b0;
      row_q       <= '0;
      for (int i = 0; i < N; i++) begin
        a_buf_q[i]   <= '0;
        b_buf_q[i]   <= '0;
        out_reg_q[i] <= '0;
        for (int j = 0; j < N; j++) begin
          prod_sign_q[i][j] <= 1'b0;
          prod_mag_q[i][j]  <= '0;
          acc_q[i][j]       <= '0;
        end
      end
    end else begin
      a_buf_q     <= a_buf_d;
      b_buf_q     <= b_buf_d;
      a_vld_q     <= a_vld_d;
      b_vld_q     <= b_vld_d;
      a_ptr_q     <= a_ptr_d;
      b_ptr_q     <= b_ptr_d;
      pad_q       <= pad_d;
      pad_mat_q   <= pad_mat_d;
      state_q     <= state_d;
      k_q         <= k_d;
      prod_vld_q  <= prod_vld_d;
      prod_last_q <= prod_last_d;
      acc_done_q  <= acc_done_d;
      prod_sign_q <= prod_sign_d;
      prod_mag_q  <= prod_mag_d;
      acc_q       <= acc_d;
      out_reg_q   <= out_reg_d;
      out_full_q  <= out_full_d;
      row_q       <= row_d;
    end
  end

endmodule

// File: tb/tb_fxp_pe_array_block.sv
// Directed self-checking bench for fxp_pe_array_block at N=4, DW=8, FRAC=3.
module tb_fxp_pe_array_block;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_in_data, rdy_in_data, in_mat, in_mat_done;
  logic [31:0] in_data;
  logic        en_out_data, rdy_out_data, out_mat_done;
  logic [31:0] out_data;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] ma [2][4][4];
  logic [7:0] mb [2][4][4];
  logic [7:0] ex [2][4][4];

  fxp_pe_array_block #(.N(4), .DW(8), .FRAC(3)) dut (
    .clk(clk), .rst(rst),
    .en_in_data(en_in_data), .rdy_in_data(rdy_in_data),
    .in_mat(in_mat), .in_mat_done(in_mat_done), .in_data(in_data),
    .en_out_data(en_out_data), .rdy_out_data(rdy_out_data),
    .out_mat_done(out_mat_done), .out_data(out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Independent integer model of C = A x B followed by requantisation.
  function automatic void computeExpected(input int id);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        int acc;
        int mag;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
          int p;
          p = int'(ma[id][i][k][6:0]) * int'(mb[id][k][j][6:0]);
          acc += (ma[id][i][k][7] ^ mb[id][k][j][7]) ? -p : p;
        end
        mag = (acc < 0) ? -acc : acc;
`ifdef FXP_PE_ARRAY_ROUND_EN
        mag = (mag + 4) / 8;
`else
        mag = mag / 8;
`endif
        if (mag > 127) mag = 127;
        ex[id][i][j] = {(acc < 0 && mag != 0), 7'(mag)};
      end
    end
  endfunction

  function automatic logic [31:0] packRow(input int id, input int r);
    logic [31:0] d;
    for (int j = 0; j < 4; j++) d[8*j +: 8] = ex[id][r][j];
    return d;
  endfunction

  task automatic clearMats(input int id);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[id][i][j] = 8'h00;
        mb[id][i][j] = 8'h00;
        ex[id][i][j] = 8'h00;
      end
  endtask

  // Called 1ns after a rising edge; returns 1ns after the accepting edge.
  task automatic sendBeat(input logic mat, input logic [31:0] data, input logic done);
    int n;
    n = 0;
    en_in_data  = 1'b1;
    in_mat      = mat;
    in_data     = data;
    in_mat_done = done;
    #1;
    while (!rdy_in_data && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("in_accept", rdy_in_data, 1'b1);
    @(posedge clk); #1;
    en_in_data  = 1'b0;
    in_mat_done = 1'b0;
  endtask

  task automatic sendA(input int id, input int last_col);
    logic [31:0] d;
    for (int k = 0; k <= last_col; k++) begin
      for (int i = 0; i < 4; i++) d[8*i +: 8] = ma[id][i][k];
      sendBeat(1'b0, d, k == last_col);
    end
  endtask

  task automatic sendB(input int id);
    logic [31:0] d;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) d[8*j +: 8] = mb[id][k][j];
      sendBeat(1'b1, d, k == 3);
    end
  endtask

  task automatic applyStimulus(input int id);
    sendA(id, 3);
    sendB(id);
  endtask

  task automatic waitValid(input string tag);
    int n;
    n = 0;
    while (!en_out_data && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(tag, en_out_data, 1'b1);
  endtask

  // strict: every row must already be valid with no wait (no gaps allowed).
  task automatic collectResult(input int id, input bit strict);
    rdy_out_data = 1'b1;
    for (int r = 0; r < 4; r++) begin
      if (!strict) waitValid($sformatf("valid_res%0d_r%0d", id, r));
      else checkOutput($sformatf("nogap_res%0d_r%0d", id, r), en_out_data, 1'b1);
      checkOutput($sformatf("data_res%0d_r%0d", id, r), out_data, packRow(id, r));
      checkOutput($sformatf("done_res%0d_r%0d", id, r), out_mat_done, r == 3);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [7:0] brow [4];
    brow[0] = 8'h01; brow[1] = 8'h82; brow[2] = 8'h10; brow[3] = 8'h7F;
    rst = 1'b1;
    en_in_data = 1'b0; in_mat = 1'b0; in_mat_done = 1'b0; in_data = '0;
    rdy_out_data = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rdy_in", rdy_in_data, 1'b0);
    checkOutput("reset_en_out", en_out_data, 1'b0);
    checkOutput("reset_done", out_mat_done, 1'b0);
    checkOutput("reset_data", out_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_out_data = 1'b1;

    // Identity: A = I (1.0), every B row {0x01,0x82,0x10,0x7F}; C rows equal B rows.
    clearMats(0);
    for (int i = 0; i < 4; i++) begin
      ma[0][i][i] = 8'h08;
      for (int j = 0; j < 4; j++) begin
        mb[0][i][j] = brow[j];
        ex[0][i][j] = brow[j];
      end
    end
    applyStimulus(0);
    @(posedge clk); #1;
    checkOutput("lat_edge1", en_out_data, 1'b0);
    @(posedge clk); #1;
    checkOutput("lat_edge2", en_out_data, 1'b0);
    @(posedge clk); #1;
    checkOutput("lat_edge3", en_out_data, 1'b1);
    collectResult(0, 1'b1);

    // Zero-pad: A ends after column 1, columns 2-3 must behave as zero.
    clearMats(0);
    for (int i = 0; i < 4; i++) begin
      ma[0][i][0] = 8'(8 * (i + 1));
      ma[0][i][1] = 8'h80 | 8'(4 * (i + 1));
      for (int j = 0; j < 4; j++) mb[0][i][j] = 8'(8 + 4 * j + 3 * i);
    end
    computeExpected(0);
    sendA(0, 1);
    in_mat = 1'b1;
    checkOutput("pad_rdy_c0", rdy_in_data, 1'b0);
    @(posedge clk); #1;
    checkOutput("pad_rdy_c1", rdy_in_data, 1'b0);
    @(posedge clk); #1;
    checkOutput("pad_rdy_c2", rdy_in_data, 1'b1);
    sendB(0);
    collectResult(0, 1'b0);

    // Rounding: 2^-3 * 2^-1 = 2^-4 is exactly half an output LSB.
    clearMats(0);
    ma[0][0][0] = 8'h01;
    mb[0][0][0] = 8'h04;
`ifdef FXP_PE_ARRAY_ROUND_EN
    ex[0][0][0] = 8'h01;
`else
    ex[0][0][0] = 8'h00;
`endif
    applyStimulus(0);
    collectResult(0, 1'b0);

    // Negative result below half an LSB must read as +0.
    clearMats(0);
    ma[0][0][0] = 8'h81;
    mb[0][0][0] = 8'h02;
    applyStimulus(0);
    collectResult(0, 1'b0);

    // Saturation, positive and negative.
    for (int s = 0; s < 2; s++) begin
      clearMats(0);
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          ma[0][i][j] = 8'h7F;
          mb[0][i][j] = (s == 0) ? 8'h7F : 8'hFF;
          ex[0][i][j] = (s == 0) ? 8'h7F : 8'hFF;
        end
      applyStimulus(0);
      collectResult(0, 1'b0);
    end

    // Overlap: result 0 stalled in the output register while pair 1 computes.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[0][i][j] = {((i + j) % 3 == 0), 7'(3 * i + 5 * j + 1)};
        mb[0][i][j] = {((i * j) % 2 == 1), 7'(2 * i + 7 * j + 2)};
        ma[1][i][j] = {((i + 2 * j) % 4 == 1), 7'(11 * i + 2 * j + 4)};
        mb[1][i][j] = {((i + j) % 2 == 0), 7'(4 * i + 3 * j + 1)};
      end
    computeExpected(0);
    computeExpected(1);
    rdy_out_data = 1'b0;
    applyStimulus(0);
    waitValid("ovl_res0_valid");
    applyStimulus(1);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("ovl_stall_valid", en_out_data, 1'b1);
    checkOutput("ovl_stall_data", out_data, packRow(0, 0));
    checkOutput("ovl_stall_done", out_mat_done, 1'b0);
    collectResult(0, 1'b1);
    collectResult(1, 1'b1);
    checkOutput("ovl_no_extra", en_out_data, 1'b0);

    // Reset mid-drain: discard the rest of result 0 and a partial A, then run pair 1.
    rdy_out_data = 1'b0;
    applyStimulus(0);
    waitValid("rst_res0_valid");
    rdy_out_data = 1'b1;
    checkOutput("rst_row0", out_data, packRow(0, 0));
    @(posedge clk); #1;
    checkOutput("rst_row1", out_data, packRow(0, 1));
    @(posedge clk); #1;
    rdy_out_data = 1'b0;
    sendBeat(1'b0, 32'h5A3C_7E11, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("rst_en_out", en_out_data, 1'b0);
    checkOutput("rst_data", out_data, 32'h0);
    checkOutput("rst_rdy_in", rdy_in_data, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_out_data = 1'b1;
    applyStimulus(1);
    collectResult(1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rst_no_stale", en_out_data, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
